spi_flash_rom_loader: RTL and testbench

- Boot-time stage directly upstream of the instruction ROM.
- After reset, wakes the iCEBreaker SPI flash and issues one READ (0x03) at a fixed offset. It streams WORD_COUNT big-endian 16-bit words and writes each into ROM through a one-cycle rom_load strobe.
- Drives the FLASH_* pins directly.
- Holds the CPU off via busy until the image is loaded; done stays high afterwards.

---
 rtl/spi_flash_rom_loader.sv | 147 ++++++++++++++
 tb/tb_spi_flash_rom_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rom_loader.sv
// Boot loader that copies a program image from SPI flash into instruction ROM.
// Wakes the flash with 0xAB, waits a guard time, issues one READ (0x03) at
// FLASH_START_ADDR and streams WORD_COUNT big-endian 16-bit words, writing each
// word into ROM with a one-cycle rom_load strobe.
// Ports:
//   CLK, reset (async, active high), start (one-cycle load request)
//   FLASH_IO1 (MISO) in; FLASH_SCK/SSB/IO0 (mode-0 SPI), FLASH_IO2/IO3 tied high
//   rom_address/rom_data/rom_load: ROM write port
//   busy: load in progress; done: sticky completion flag
module spi_flash_rom_loader #(
  parameter logic [23:0] FLASH_START_ADDR = 24'h100000,
  parameter int          WORD_COUNT       = 16384,
  parameter int          SCK_DIV          = 2,
  parameter int          WAKE_GUARD       = 48
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        FLASH_IO1,
  output logic        FLASH_SCK,
  output logic        FLASH_SSB,
  output logic        FLASH_IO0,
  output logic        FLASH_IO2,
  output logic        FLASH_IO3,
  output logic [14:0] rom_address,
  output logic [15:0] rom_data,
  output logic        rom_load,
  output logic        busy,
  output logic        done
);

  localparam int          DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int          GRD_W     = (WAKE_GUARD > 1) ? $clog2(WAKE_GUARD) : 1;
  localparam logic [14:0] LAST_ADDR = 15'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAKE_CMD, S_WAKE_GUARD, S_READ_CMD, S_READ_WORD, S_WRITE, S_FINISH
  } state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [4:0]         bit_cnt;
  logic [GRD_W-1:0]   guard_cnt;
  logic [31:0]        tx_sr;
  logic [15:0]        rx_sr;
  logic               shifting, half_end, sck_rise, sck_fall, last_fall, start_go;
  logic [4:0]         last_bit;

  assign FLASH_IO0 = tx_sr[31];
  assign FLASH_IO2 = 1'b1;
  assign FLASH_IO3 = 1'b1;

  always_comb begin
    shifting   = 1'b0;
    last_bit   = 5'd0;
    state_next = state;
    case (state)
      S_WAKE_CMD:  begin shifting = 1'b1; last_bit = 5'd7;  end
      S_READ_CMD:  begin shifting = 1'b1; last_bit = 5'd31; end
      S_READ_WORD: begin shifting = 1'b1; last_bit = 5'd15; end
      default:     ;
    endcase
    // Each bit is SCK_DIV cycles low then SCK_DIV cycles high; a bit ends on
    // the falling edge so SCK is always low when a shift state is left.
    half_end  = shifting && (div_cnt == DIV_W'(SCK_DIV - 1));
    sck_rise  = half_end && !FLASH_SCK;
    sck_fall  = half_end && FLASH_SCK;
    last_fall = sck_fall && (bit_cnt == last_bit);
    start_go  = (state == S_IDLE) && start;
    case (state)
      S_IDLE:       if (start_go) state_next = S_WAKE_CMD;
      S_WAKE_CMD:   if (last_fall) state_next = S_WAKE_GUARD;
      S_WAKE_GUARD: if (guard_cnt == GRD_W'(WAKE_GUARD - 1)) state_next = S_READ_CMD;
      S_READ_CMD:   if (last_fall) state_next = S_READ_WORD;
      S_READ_WORD:  if (last_fall) state_next = S_WRITE;
      // Flash auto-increments while SSB stays low, so the next word just
      // continues clocking with no new command.
      S_WRITE:      state_next = (rom_address == LAST_ADDR) ? S_FINISH : S_READ_WORD;
      S_FINISH:     state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // SPI shift engine
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      FLASH_SCK <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      guard_cnt <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else begin
      if (shifting) begin
        div_cnt <= half_end ? '0 : div_cnt + 1'b1;
        if (half_end) FLASH_SCK <= ~FLASH_SCK;
        if (sck_fall) begin
          bit_cnt <= last_fall ? 5'd0 : bit_cnt + 5'd1;
          tx_sr   <= {tx_sr[30:0], 1'b0};
        end
        // MISO is captured on the cycle SCK rises; flash drove it on the fall.
        if (sck_rise && state == S_READ_WORD) rx_sr <= {rx_sr[14:0], FLASH_IO1};
      end else begin
        div_cnt   <= '0;
        bit_cnt   <= '0;
        FLASH_SCK <= 1'b0;
      end
      guard_cnt <= (state == S_WAKE_GUARD) ? guard_cnt + 1'b1 : '0;
      if (start_go)
        tx_sr <= {8'hAB, 24'h0};
      else if (state == S_WAKE_GUARD && state_next == S_READ_CMD)
        tx_sr <= {8'h03, FLASH_START_ADDR};
    end
  end

  // Pin / ROM-port registers, driven from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      FLASH_SSB   <= 1'b1;
      rom_address <= '0;
      rom_data    <= '0;
      rom_load    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      FLASH_SSB <= !(state_next inside {S_WAKE_CMD, S_READ_CMD, S_READ_WORD, S_WRITE});
      rom_load  <= (state_next == S_WRITE);
      if (start_go) begin
        busy        <= 1'b1;
        done        <= 1'b0;
        rom_address <= '0;
      end else if (state_next == S_FINISH) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (state == S_WRITE && state_next == S_READ_WORD) rom_address <= rom_address + 15'd1;
      if (state == S_READ_WORD && state_next == S_WRITE) rom_data <= rx_sr;
    end
  end

endmodule

// File: tb/tb_spi_flash_rom_loader.sv
`timescale 1ns/1ps
module tb_spi_flash_rom_loader;
  localparam int          WC   = 4;
  localparam logic [23:0] BASE = 24'h100000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic reset = 1'b1, start = 1'b0, start1 = 1'b0;
  logic miso = 1'b0, sck, ssb, mosi, io2, io3, rload, busy, done;
  logic [14:0] raddr; logic [15:0] rdata;
  logic miso1 = 1'b0, sck1, ssb1, mosi1, io2_1, io3_1, rload1, busy1, done1;
  logic [14:0] raddr1; logic [15:0] rdata1;

  spi_flash_rom_loader #(.FLASH_START_ADDR(BASE), .WORD_COUNT(WC), .SCK_DIV(2), .WAKE_GUARD(48)) dut (
    .CLK(CLK), .reset(reset), .start(start), .FLASH_IO1(miso), .FLASH_SCK(sck), .FLASH_SSB(ssb),
    .FLASH_IO0(mosi), .FLASH_IO2(io2), .FLASH_IO3(io3), .rom_address(raddr), .rom_data(rdata),
    .rom_load(rload), .busy(busy), .done(done));

  spi_flash_rom_loader #(.FLASH_START_ADDR(BASE), .WORD_COUNT(1), .SCK_DIV(1), .WAKE_GUARD(48)) dut1 (
    .CLK(CLK), .reset(reset), .start(start1), .FLASH_IO1(miso1), .FLASH_SCK(sck1), .FLASH_SSB(ssb1),
    .FLASH_IO0(mosi1), .FLASH_IO2(io2_1), .FLASH_IO3(io3_1), .rom_address(raddr1), .rom_data(rdata1),
    .rom_load(rload1), .busy(busy1), .done(done1));

  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- SPI flash model (main DUT) ----------------
  logic [7:0] fmem [0:7];
  int         f_bits = 0, f_idx;
  logic [31:0] f_hdr = '0;
  logic [7:0] f_byte;
  logic [7:0] cmd_q [$];
  int         txn_q [$];
  longint     t_ssb_rise = 0, t_rise = 0, min_per = 1000000;
  int         gap_wake = -1, bad_high = 0;

  always @(posedge ssb) begin
    if (f_bits > 0) txn_q.push_back(f_bits);
    f_bits = 0; f_hdr = '0; t_ssb_rise = $time;
  end
  always @(negedge ssb)
    if (txn_q.size() > 0 && txn_q[$] == 8) gap_wake = int'(($time - t_ssb_rise) / 10);
  always @(posedge sck) if (!ssb) begin
    if (f_bits < 32) begin
      f_hdr = {f_hdr[30:0], mosi};
      if (f_bits % 8 == 7) cmd_q.push_back(f_hdr[7:0]);
    end
    if (t_rise != 0 && ($time - t_rise) < min_per) min_per = $time - t_rise;
    t_rise = $time;
    f_bits++;
  end
  always @(negedge sck) begin
    if (!reset && t_rise != 0 && ($time - t_rise) != 20) bad_high++;
    if (!ssb && f_hdr[31:24] == 8'h03 && f_bits >= 32) begin
      f_idx  = int'(f_hdr[23:0] - BASE) + (f_bits - 32) / 8;
      f_byte = (f_idx >= 0 && f_idx < 8) ? fmem[f_idx] : 8'hFF;
      miso   = f_byte[7 - (f_bits - 32) % 8];
    end
  end

  // ---------------- minimal flash model (single-word DUT) ----------------
  int b1 = 0; logic [15:0] w1 = '0; longint t1_rise = 0, min_per1 = 1000000; int strobes1 = 0;
  always @(posedge sck1 or posedge ssb1)
    if (ssb1) b1 = 0;
    else begin
      if (t1_rise != 0 && ($time - t1_rise) < min_per1) min_per1 = $time - t1_rise;
      t1_rise = $time;
      b1++;
    end
  always @(negedge sck1) if (!ssb1 && b1 >= 32 && b1 < 48) miso1 = w1[47 - b1];
  always @(negedge CLK) if (rload1) strobes1++;

  // ---------------- scoreboard monitor ----------------
  typedef struct packed { logic [14:0] a; logic [15:0] d; } exp_t;
  exp_t   sb_q [$];
  exp_t   e;
  int     load_strobes = 0;
  longint t_strobe = 0;
  logic   prev_load = 1'b0;

  always @(negedge CLK) begin
    if (rload) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: rom_load at addr %0d, expected no strobe", raddr);
      end else begin
        e = sb_q.pop_front();
        chk("rom_address", 32'(raddr), 32'(e.a));
        chk("rom_data", 32'(rdata), 32'(e.d));
      end
      chk("strobe_width", 32'(prev_load), 0);
      if (load_strobes > 0) chk("strobe_spacing", 32'(($time - t_strobe) / 10), 65);
      t_strobe = $time;
      load_strobes++;
    end
    prev_load = rload;
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    start = 1'b1; @(negedge CLK); start = 1'b0;
  endtask

  task automatic begin_load();
    load_strobes = 0; cmd_q.delete(); txn_q.delete(); gap_wake = -1; min_per = 1000000; t_rise = 0;
    for (int i = 0; i < WC; i++) sb_q.push_back({15'(i), fmem[2*i], fmem[2*i+1]});
    pulse_start();
    chk("busy_on_start", 32'(busy), 1);
    chk("done_cleared", 32'(done), 0);
  endtask

  task automatic wait_strobes(input int n);
    int c = 0;
    while (load_strobes < n && c < 3000) begin @(negedge CLK); c++; end
    if (load_strobes < n) begin checks++; $display("FAIL strobe_timeout: %0d strobes, expected %0d", load_strobes, n); end
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 3000) begin @(negedge CLK); c++; end
    checks++;
    if (done) passes++;
    else $display("FAIL %s_timeout: done=%0b after %0d cycles, expected 1", name, done, c);
  endtask

  task automatic check_load(input string name);
    logic [7:0] want [5];
    want = '{8'hAB, 8'h03, BASE[23:16], BASE[15:8], BASE[7:0]};
    chk({name, "_strobes"}, 32'(load_strobes), WC);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_ssb"}, 32'(ssb), 1);
    chk({name, "_sb_left"}, 32'(sb_q.size()), 0);
    chk({name, "_txns"}, 32'(txn_q.size()), 2);
    chk({name, "_wake_bits"}, (txn_q.size() > 0) ? 32'(txn_q[0]) : 32'hFFFF, 8);
    chk({name, "_read_bits"}, (txn_q.size() > 1) ? 32'(txn_q[1]) : 32'hFFFF, 32 + 16*WC);
    chk({name, "_cmd_bytes"}, 32'(cmd_q.size()), 5);
    for (int i = 0; i < 5; i++)
      chk({name, "_cmd"}, (cmd_q.size() > i) ? 32'(cmd_q[i]) : 32'hFFFF, 32'(want[i]));
    checks++;
    if (gap_wake >= 48) passes++;
    else $display("FAIL %s_wake_gap: got %0d cycles, expected >= 48", name, gap_wake);
    chk({name, "_sck_period"}, 32'(min_per / 10), 4);
    chk({name, "_sck_high"}, 32'(bad_high), 0);
  endtask

  initial begin
    // start coincident with reset must be ignored
    start = 1'b1;
    repeat (2) @(negedge CLK);
    start = 1'b0;
    chk("rst_ssb", 32'(ssb), 1);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_load", 32'(rload), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(raddr), 0);
    chk("rst_data", 32'(rdata), 0);
    chk("io2", 32'(io2), 1);
    chk("io3", 32'(io3), 1);
    chk("rst_ssb1", 32'(ssb1), 1);
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    chk("start_during_reset_ignored", 32'(busy), 0);

    // Directed image, plus a stray start after the 2nd word
    fmem = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF};
    begin_load();
    wait_strobes(2);
    pulse_start();
    wait_done("fixed");
    check_load("fixed");

    // Reset after 2nd strobe
    for (int i = 0; i < 8; i++) fmem[i] = 8'($urandom);
    repeat (5) @(negedge CLK);
    begin_load();
    wait_strobes(2);
    #2 reset = 1'b1;
    #1;
    chk("abort_ssb", 32'(ssb), 1);
    chk("abort_sck", 32'(sck), 0);
    chk("abort_busy", 32'(busy), 0);
    sb_q.delete();
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (600) @(negedge CLK);
    chk("abort_no_more_strobes", 32'(load_strobes), 2);
    chk("abort_done", 32'(done), 0);

    // Fresh loads with random images and random stray starts
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) fmem[i] = 8'($urandom);
      begin_load();
      repeat ($urandom_range(10, 300)) @(negedge CLK);
      pulse_start();
      wait_done("rand");
      check_load("rand");
      repeat ($urandom_range(1, 20)) @(negedge CLK);
    end

    // Single word, SCK_DIV=1
    w1 = 16'($urandom);
    start1 = 1'b1; @(negedge CLK); start1 = 1'b0;
    begin
      int c = 0;
      while (!rload1 && c < 2000) begin @(negedge CLK); c++; end
      chk("one_strobe_seen", 32'(rload1), 1);
      chk("one_addr", 32'(raddr1), 0);
      chk("one_data", 32'(rdata1), 32'(w1));
      @(negedge CLK);
      chk("one_done", 32'(done1), 1);
      chk("one_busy", 32'(busy1), 0);
      chk("one_ssb", 32'(ssb1), 1);
    end
    repeat (100) @(negedge CLK);
    chk("one_strobe_count", 32'(strobes1), 1);
    chk("one_sck_period", 32'(min_per1 / 10), 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
